// File: rtl/mips32_ifetch.sv
// Instruction fetch stage for the mips32 core: fetch PC, imem request/response
// handling and a small instruction queue with redirect flush.
module mips32_ifetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] fetchPc;
    logic [WIDTH-1:0] respPc;
    logic [WIDTH-1:0] redirPc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    drop;
    logic [CW-1:0]    count;
    logic [CW:0]      credit;
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic [WIDTH-1:0] qInstr [QDEPTH];
    logic [WIDTH-1:0] qPc    [QDEPTH];
    logic             xfer;
    logic             keep;
    logic             dropRsp;
    logic             pop;

    // Requests only while a queue slot is reserved for every kept response.
    assign credit    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req  = !rst && !redirect && (credit < (CW+1)'(QDEPTH));
    assign imem_addr = fetchPc;

    assign xfer    = imem_req && imem_gnt;
    assign dropRsp = imem_rvalid && (drop != '0);
    assign keep    = imem_rvalid && (drop == '0) && !redirect;
    assign pop     = instr_valid && instr_ready && !redirect;
    assign redirPc = {redirect_pc[WIDTH-1:2], 2'b00};

    assign instr_valid = (count != '0);
    assign instr       = qInstr[rdPtr];
    assign instr_pc    = qPc[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
        end else if (redirect) begin
            fetchPc     <= redirPc;
            respPc      <= redirPc;
            outstanding <= '0;
            // Everything still in flight becomes stale; one may land now.
            drop        <= drop + outstanding - CW'(imem_rvalid);
            count       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
        end else begin
            if (xfer)
                fetchPc <= fetchPc + WIDTH'(4);
            if (keep) begin
                respPc <= respPc + WIDTH'(4);
                wrPtr  <= wrPtr + AW'(1);
            end
            if (pop)
                rdPtr <= rdPtr + AW'(1);
            outstanding <= outstanding + CW'(xfer) - CW'(keep);
            drop        <= drop - CW'(dropRsp);
            count       <= count + CW'(keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            qInstr[wrPtr] <= imem_rdata;
            qPc[wrPtr]    <= respPc;
        end
    end
endmodule

// File: tb/tb_mips32_ifetch.sv
// Bench for mips32_ifetch: in-order memory model with random latency and an
// expected-PC-stream reference checked on every consumed instruction.
module tb_mips32_ifetch;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    mips32_ifetch #(.WIDTH(32), .RESET_PC(RPC), .QDEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cycle = 0;
    int          lastDue = 0;
    int          latMin = 1;
    int          latMax = 1;
    bit          randGnt = 1'b0;
    int          nChecks = 0;
    int          nFail = 0;
    int          xfers = 0;
    int          pops = 0;
    logic [31:0] expPc = RPC;
    bit          sValid, sReq;
    logic [31:0] sAddr;
    bit          flushChk = 0, rstChk = 0, holdAddr = 0, holdHead = 0;
    logic [31:0] flushTarget, savedAddr, savedPc, savedInstr;

    function automatic logic [31:0] mix(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic expectEq(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        int lat, due;
        @(negedge clk);
        sValid = instr_valid;
        sReq   = imem_req;
        sAddr  = imem_addr;
        if (flushChk) begin
            expectEq("flushValid", instr_valid, 0);
            if (imem_req) expectEq("flushAddr", imem_addr, flushTarget);
        end
        if (rstChk) begin
            expectEq("rstValid", instr_valid, 0);
            expectEq("rstAddr", imem_addr, RPC);
        end
        if (holdAddr && !redirect && !rst) begin
            expectEq("reqHold", imem_req, 1);
            expectEq("addrHold", imem_addr, savedAddr);
        end
        if (holdHead) begin
            expectEq("headValid", instr_valid, 1);
            expectEq("headPc", instr_pc, savedPc);
            expectEq("headInstr", instr, savedInstr);
        end
        if (rst || redirect) expectEq("reqBlocked", imem_req, 0);
        if (imem_req) expectEq("align", imem_addr[1:0], 0);

        flushChk = redirect && !rst;
        rstChk   = rst;
        holdAddr = imem_req && !imem_gnt && !redirect && !rst;
        holdHead = instr_valid && !instr_ready && !redirect && !rst;
        savedAddr  = imem_addr;
        savedPc    = instr_pc;
        savedInstr = instr;
        flushTarget = {redirect_pc[31:2], 2'b00};

        if (rst) begin
            pend.delete();
            lastDue = 0;
            expPc = RPC;
        end else begin
            if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
            if (redirect) begin
                expPc = flushTarget;
            end else if (instr_valid && instr_ready) begin
                expectEq("pc", instr_pc, expPc);
                expectEq("data", instr, mix(expPc));
                expPc += 32'd4;
                pops++;
            end
            if (imem_req && imem_gnt) begin
                lat = $urandom_range(latMax, latMin);
                due = cycle + lat;
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                pend.push_back('{addr: imem_addr, due: due});
                xfers++;
            end
        end

        @(posedge clk);
        #1;
        cycle++;
        if (pend.size() > 0 && pend[0].due <= cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mix(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = randGnt ? 1'($urandom_range(1, 0)) : 1'b1;
    endtask

    task automatic waitPc(input logic [31:0] target, input int bound);
        int n = 0;
        while (expPc != target && n < bound) begin
            tick();
            n++;
        end
        expectEq("reachPc", expPc, target);
    endtask

    initial begin
        int first, p0, x0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        instr_ready = 1'b1;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) expectEq("firstReq", sReq, 1);
            if (sValid && first < 0) first = i;
        end
        expectEq("firstValid", first, 2);
        p0 = pops;
        repeat (10) tick();
        expectEq("throughput", pops - p0, 10);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr_ready = 1'b0;
        x0 = xfers;
        repeat (12) tick();
        expectEq("bpXfers", xfers - x0, 4);
        expectEq("bpReqLow", sReq, 0);
        instr_ready = 1'b1;
        waitPc(32'h20, 40);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        latMin = 3;
        latMax = 3;
        repeat (10) tick();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        waitPc(32'h108, 40);

        latMin = 1;
        latMax = 1;
        repeat (10) tick();
        redirect = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect = 1'b0;
        waitPc(32'h48, 20);

        randGnt = 1'b1;
        latMax = 2;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        waitPc(32'h8, 100);
        randGnt = 1'b0;
        latMax = 1;

        instr_ready = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        expectEq("relReq", sReq, 1);
        expectEq("relAddr", sAddr, RPC);
        instr_ready = 1'b1;
        waitPc(32'h10, 30);

        randGnt = 1'b1;
        latMin = 1;
        latMax = 4;
        for (int i = 0; i < 2000; i++) begin
            instr_ready = ($urandom_range(3, 0) != 0);
            if (redirect)
                redirect = ($urandom_range(2, 0) == 0);
            else
                redirect = ($urandom_range(19, 0) == 0);
            if ($urandom_range(1, 0) == 0)
                redirect_pc = $urandom & 32'h0000_0FFF;
            else
                redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            tick();
        end
        redirect = 1'b0;
        instr_ready = 1'b1;
        randGnt = 1'b0;
        p0 = 0;
        waitPc(expPc + 32'd32, 100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end
endmodule
